// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the vertex sequencer: FSM state encoding,
// 48-bit {X,Y,Z} vertex packing offsets and small field helpers.
package pipeline_ctrl_pkg;

  localparam int COORD_W   = 16;
  localparam int VTX_W     = 3 * COORD_W;
  localparam int VTX_X_LSB = 32;
  localparam int VTX_Y_LSB = 16;
  localparam int VTX_Z_LSB = 0;

  // Settle counter width covers SETTLE_CYCLES up to 255.
  localparam int SETTLE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [VTX_W-1:0]   vertex_t;

  function automatic coord_t vtx_x(input vertex_t v);
    return v[VTX_X_LSB +: COORD_W];
  endfunction

  function automatic coord_t vtx_y(input vertex_t v);
    return v[VTX_Y_LSB +: COORD_W];
  endfunction

  function automatic coord_t vtx_z(input vertex_t v);
    return v[VTX_Z_LSB +: COORD_W];
  endfunction

  function automatic vertex_t vtx_pack(input coord_t x, input coord_t y, input coord_t z);
    vertex_t v;
    v = '0;
    v[VTX_X_LSB +: COORD_W] = x;
    v[VTX_Y_LSB +: COORD_W] = y;
    v[VTX_Z_LSB +: COORD_W] = z;
    return v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
// Clear is synchronous and has priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold once saturated, clear on clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vertex_sequencer.sv
// Vertex sequencer: accepts one vertex, holds it on the graphics pipeline
// inputs for SETTLE_CYCLES cycles, captures the projected result and hands
// it downstream with a valid/ready handshake. Keeps saturating statistics.
// Optional build macro: VSEQ_EXC_DROP_EN -- results flagged with an
// exception are counted but dropped instead of being presented downstream.
module vertex_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_VtxValid,
  output logic             o_VtxReady,
  input  logic [47:0]      i_Vertex,
  output logic [47:0]      o_PipeVertex,
  input  logic [15:0]      i_PipeX,
  input  logic [15:0]      i_PipeY,
  input  logic             i_PipeExc,
  output logic             o_OutValid,
  input  logic             i_OutReady,
  output logic [15:0]      o_X,
  output logic [15:0]      o_Y,
  output logic             o_Exception,
  output logic             o_Busy,
  output logic [CNT_W-1:0] o_VtxCount,
  output logic [CNT_W-1:0] o_ExcCount
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                accept;
  logic                capture;
  logic                forward;

  assign accept  = (state == ST_IDLE) && i_VtxValid;
  assign capture = (state == ST_SETTLE) && (settle_cnt == '0);

`ifdef VSEQ_EXC_DROP_EN
  // Exception results are counted but never reach OUT.
  assign forward = capture && !i_PipeExc;
`else
  assign forward = capture;
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    if (!i_Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no branch leaves state_next unassigned and
    // no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:   if (i_VtxValid) state_next = ST_SETTLE;
      ST_SETTLE: if (capture)    state_next = forward ? ST_OUT : ST_IDLE;
      ST_OUT:    if (i_OutReady) state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register only.
  always_comb begin
    o_VtxReady = (state == ST_IDLE);
    o_OutValid = (state == ST_OUT);
    o_Busy     = (state != ST_IDLE);
  end

  // Vertex hold register, settle counter and result capture.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      o_PipeVertex <= '0;
      settle_cnt   <= '0;
      o_X          <= '0;
      o_Y          <= '0;
      o_Exception  <= 1'b0;
    end else begin
      if (accept) begin
        o_PipeVertex <= i_Vertex;
        settle_cnt   <= SETTLE_LOAD;
      end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (forward) begin
        o_X         <= i_PipeX;
        o_Y         <= i_PipeY;
        o_Exception <= i_PipeExc;
      end
    end
  end

  // Statistics: every capture counts, exception captures also count separately.
  sat_counter #(.WIDTH(CNT_W)) u_vtx_cnt (
    .clk   (i_Clk),
    .clr   (!i_Reset_n),
    .inc   (capture),
    .count (o_VtxCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_exc_cnt (
    .clk   (i_Clk),
    .clr   (!i_Reset_n),
    .inc   (capture && i_PipeExc),
    .count (o_ExcCount)
  );

endmodule

// File: tb/tb_vertex_sequencer.sv
// Directed bench for vertex_sequencer with a scoreboard of expected results.
// A pass-through pipeline stub returns X/Y from the held vertex and flags an
// exception when Z is zero. A second instance with CNT_W=3 shares all inputs
// and is used for counter saturation.
module tb_vertex_sequencer;
  import pipeline_ctrl_pkg::*;

  localparam int SETTLE = 4;
`ifdef VSEQ_EXC_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vtx_valid;
  logic [47:0] vertex;
  logic        out_ready;

  logic        vtx_ready, out_valid, exc, busy;
  logic [47:0] pipe_vertex;
  logic [15:0] pipe_x, pipe_y, x, y;
  logic        pipe_exc;
  logic [15:0] vtx_count, exc_count;

  logic        s_vtx_ready, s_out_valid, s_exc, s_busy;
  logic [47:0] s_pipe_vertex;
  logic [15:0] s_x, s_y;
  logic [2:0]  s_vtx_count, s_exc_count;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   out_cyc = 0;
  int   exp_vtx = 0;
  int   exp_exc = 0;
  exp_t sb[$];
  coord_t last_fx = '0;
  coord_t last_fy = '0;
  logic   last_fexc = 1'b0;
  vertex_t last_v = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipeline stub.
  assign pipe_x   = vtx_x(pipe_vertex);
  assign pipe_y   = vtx_y(pipe_vertex);
  assign pipe_exc = (vtx_z(pipe_vertex) == 16'h0000);

  vertex_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) u_dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_VtxValid(vtx_valid), .o_VtxReady(vtx_ready),
    .i_Vertex(vertex), .o_PipeVertex(pipe_vertex), .i_PipeX(pipe_x), .i_PipeY(pipe_y),
    .i_PipeExc(pipe_exc), .o_OutValid(out_valid), .i_OutReady(out_ready), .o_X(x),
    .o_Y(y), .o_Exception(exc), .o_Busy(busy), .o_VtxCount(vtx_count), .o_ExcCount(exc_count)
  );

  vertex_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(3)) u_sat (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_VtxValid(vtx_valid), .o_VtxReady(s_vtx_ready),
    .i_Vertex(vertex), .o_PipeVertex(s_pipe_vertex), .i_PipeX(pipe_x), .i_PipeY(pipe_y),
    .i_PipeExc(pipe_exc), .o_OutValid(s_out_valid), .i_OutReady(out_ready), .o_X(s_x),
    .o_Y(s_y), .o_Exception(s_exc), .o_Busy(s_busy), .o_VtxCount(s_vtx_count), .o_ExcCount(s_exc_count)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sat7(input int n);
    return (n > 7) ? 7 : n;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_vtx_count"}, 48'(vtx_count), 48'(exp_vtx));
    check({tag, "_exc_count"}, 48'(exc_count), 48'(exp_exc));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!vtx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 48'(vtx_ready), 48'(1));
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    out_cyc = cyc;
    check("out_timeout", 48'(out_valid), 48'(1));
  endtask

  // Present a vertex for one cycle (DUT in IDLE) and record the expected result.
  task automatic drive_vertex(input vertex_t v);
    exp_t e;
    e.x   = vtx_x(v);
    e.y   = vtx_y(v);
    e.exc = (vtx_z(v) == 16'h0000);
    if (!(DROP && e.exc)) sb.push_back(e);
    last_v    = v;
    vertex    = v;
    vtx_valid = 1'b1;
    @(negedge clk);
    vtx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 48'(1), 48'(0));
    end else begin
      e = sb.pop_front();
      check({tag, "_x"}, 48'(x), 48'(e.x));
      check({tag, "_y"}, 48'(y), 48'(e.y));
      check({tag, "_exc"}, 48'(exc), 48'(e.exc));
      last_fx   = e.x;
      last_fy   = e.y;
      last_fexc = e.exc;
    end
  endtask

  // Full transaction with out_ready already high.
  task automatic run_vertex(input string tag, input vertex_t v);
    logic is_exc;
    is_exc = (vtx_z(v) == 16'h0000);
    wait_ready();
    drive_vertex(v);
    exp_vtx++;
    if (is_exc) exp_exc++;
    if (!(DROP && is_exc)) begin
      wait_out();
      pop_check(tag);
    end else begin
      for (int i = 0; i <= SETTLE; i++) begin
        check({tag, "_drop_no_valid"}, 48'(out_valid), 48'(0));
        @(negedge clk);
      end
      check({tag, "_drop_keep_x"}, 48'(x), 48'(last_fx));
      check({tag, "_drop_keep_exc"}, 48'(exc), 48'(last_fexc));
    end
  endtask

  initial begin
    int prev;
    int fwd_before;
    vertex_t v;

    rst_n     = 1'b0;
    vtx_valid = 1'b0;
    vertex    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("rst_vtx_ready", 48'(vtx_ready), 48'(1));
    check("rst_out_valid", 48'(out_valid), 48'(0));
    check("rst_busy", 48'(busy), 48'(0));
    check("rst_pipe_vertex", pipe_vertex, 48'(0));
    check("rst_xy", {x, y}, 48'(0));
    check_counts("rst");

    // Single vertex: result valid exactly SETTLE edges after acceptance.
    v = vtx_pack(16'h3C00, 16'h4000, 16'h3800);
    drive_vertex(v);
    check("single_vtx_ready", 48'(vtx_ready), 48'(0));
    check("single_busy", 48'(busy), 48'(1));
    check("single_pipe_vertex", pipe_vertex, v);
    check("single_valid_e0", 48'(out_valid), 48'(0));
    for (int i = 1; i < SETTLE; i++) begin
      @(negedge clk);
      check("single_valid_early", 48'(out_valid), 48'(0));
    end
    @(negedge clk);
    check("single_latency", 48'(out_valid), 48'(1));
    exp_vtx = 1;
    pop_check("single");
    check_counts("single");

    // Backpressure: outputs frozen, new vertex ignored while in OUT.
    vertex    = vtx_pack(16'h1111, 16'h2222, 16'h3333);
    vtx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 48'(out_valid), 48'(1));
      check("bp_xy", {x, y}, {16'h0, 16'h3C00, 16'h4000});
      check("bp_vtx_ready", 48'(vtx_ready), 48'(0));
      check("bp_pipe_vertex", pipe_vertex, v);
    end
    out_ready = 1'b1;
    vtx_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_idle", 48'(vtx_ready), 48'(1));
    check("bp_release_valid", 48'(out_valid), 48'(0));
    check("bp_release_busy", 48'(busy), 48'(0));
    check_counts("bp");

    // Streaming: 8 vertices, ready high, results in order, 6 cycles apart.
    out_ready = 1'b1;
    prev = 0;
    for (int n = 0; n < 8; n++) begin
      v = vtx_pack(16'($urandom), 16'($urandom), 16'($urandom_range(1, 65535)));
      run_vertex("stream", v);
      if (n > 0) check("stream_gap", 48'(out_cyc - prev), 48'(SETTLE + 2));
      prev = out_cyc;
    end
    check_counts("stream");

    // Exception on the second of three vertices.
    fwd_before = exp_vtx;
    run_vertex("exc1", vtx_pack(16'hAAAA, 16'h5555, 16'h0001));
    run_vertex("exc2", vtx_pack(16'h1234, 16'h5678, 16'h0000));
    run_vertex("exc3", vtx_pack(16'h0F0F, 16'hF0F0, 16'h0002));
    check("exc_count_delta", 48'(exc_count), 48'(1));
    check("exc_vtx_delta", 48'(vtx_count - 16'(fwd_before)), 48'(3));
    check("exc_sb_drained", 48'(sb.size()), 48'(0));

    // Reset two edges after acceptance discards the vertex.
    wait_ready();
    drive_vertex(vtx_pack(16'h7777, 16'h8888, 16'h9999));
    @(negedge clk);
    check("midrst_busy", 48'(busy), 48'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_vtx = 0;
    exp_exc = 0;
    last_fx = '0;
    last_fy = '0;
    last_fexc = 1'b0;
    check("midrst_vtx_ready", 48'(vtx_ready), 48'(1));
    check("midrst_pipe_vertex", pipe_vertex, 48'(0));
    check("midrst_xy", {x, y}, 48'(0));
    check_counts("midrst");
    for (int i = 0; i < SETTLE + 4; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 48'(out_valid), 48'(0));
    end
    check_counts("midrst_after");

    // Saturation: 9 exception vertices; 3-bit counters stop at 7.
    for (int n = 0; n < 9; n++) begin
      run_vertex("sat", vtx_pack(16'(n + 1), 16'(n + 100), 16'h0000));
    end
    wait_ready();
    check_counts("sat_main");
    check("sat_vtx_count", 48'(s_vtx_count), 48'(sat7(exp_vtx)));
    check("sat_exc_count", 48'(s_exc_count), 48'(sat7(exp_exc)));
    check("sat_idle", {s_vtx_ready, s_out_valid, s_busy}, 48'(3'b100));
    check("sat_pipe_vertex", s_pipe_vertex, last_v);
    check("sat_result", {s_x, s_y, 15'h0, s_exc}, {last_fx, last_fy, 15'h0, last_fexc});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vertex_sequencer.md
VERTEX_SEQUENCER -- requirements
Module: vertex_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: number of cycles the pipeline inputs are held stable before capture; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 i_Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_Reset_n  input  1  reset, synchronous, active-low.
REQ-005 i_VtxValid  input  1  upstream vertex valid.
REQ-006 o_VtxReady  output  1  sequencer accepts a vertex this cycle.
REQ-007 i_Vertex  input  48  {X,Y,Z} half-precision vertex; X in bits 47:32.
REQ-008 o_PipeVertex  output  48  registered vertex, same packing as i_Vertex; drives graphicspipeline i_VertexX/Y/Z.
REQ-009 i_PipeX, i_PipeY  input  16 each  graphicspipeline o_X/o_Y.
REQ-010 i_PipeExc  input  1  graphicspipeline o_Exception.
REQ-011 o_OutValid  output  1  projected result valid.
REQ-012 i_OutReady  input  1  downstream ready.
REQ-013 o_X, o_Y  output  16 each  captured projected coordinates.
REQ-014 o_Exception  output  1  captured divide exception.
REQ-015 o_Busy  output  1  high in every state except IDLE.
REQ-016 o_VtxCount, o_ExcCount  output  CNT_W each  vertices captured / captures with exception.

Function
REQ-017 SHALL implement an FSM with states IDLE, SETTLE, OUT.
REQ-018 o_VtxReady SHALL equal (state==IDLE), combinationally from the state register only.
REQ-019 In IDLE with i_VtxValid=1, SHALL register i_Vertex into o_PipeVertex, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-020 o_PipeVertex SHALL be stable throughout SETTLE and OUT; it changes only on acceptance.
REQ-021 In SETTLE, the counter SHALL decrement each cycle; on the cycle it reads 0, SHALL capture i_PipeX/i_PipeY/i_PipeExc into o_X/o_Y/o_Exception and go to OUT.
REQ-022 For a vertex accepted on edge k, o_OutValid SHALL first be high in the cycle after edge k+SETTLE_CYCLES.
REQ-023 In OUT, o_OutValid=1 and o_X/o_Y/o_Exception SHALL stay constant until i_OutReady=1; the FSM then returns to IDLE on that edge.
REQ-024 Back-to-back throughput with i_OutReady tied high SHALL be one vertex per SETTLE_CYCLES+2 cycles.
REQ-025 On every capture, o_VtxCount SHALL increment by 1; o_ExcCount SHALL also increment when i_PipeExc=1.
REQ-026 Both counters SHALL saturate at all-ones and not wrap.
REQ-027 i_VtxValid SHALL be ignored outside IDLE; i_OutReady SHALL be ignored outside OUT.

Reset
REQ-028 While i_Reset_n=0 at a rising edge, the block SHALL enter IDLE and clear o_PipeVertex, o_X, o_Y, o_Exception and both counters to 0; o_OutValid=0, o_Busy=0, o_VtxReady=1 after that edge.
REQ-029 Reset asserted in SETTLE or OUT SHALL discard the in-flight vertex without a capture and without a counter update.

Configuration
REQ-030 Macro VSEQ_EXC_DROP_EN, when defined: a capture with i_PipeExc=1 SHALL update the counters, SHALL NOT enter OUT, and SHALL return directly to IDLE; o_X/o_Y/o_Exception keep their previous values.
REQ-031 Without VSEQ_EXC_DROP_EN, exception results SHALL be forwarded through OUT with o_Exception=1.

Structure
REQ-032 The FSM state encoding (2-bit IDLE=0, SETTLE=1, OUT=2) and the 48-bit vertex packing field offsets SHALL live in a shared package, pipeline_ctrl_pkg.
REQ-033 A saturating counter sub-module, sat_counter (width-parameterised, with inc enable and sync clear), SHALL be instantiated for both statistics counters.

Verification
REQ-034 Single vertex: SETTLE_CYCLES=4, accept on edge 0 with pipeline stub returning X=16'h3C00 and Y=16'h4000 -> o_OutValid high after edge 4, o_X=3C00, o_Y=4000, o_VtxCount=1.
REQ-035 Backpressure: i_OutReady low for 10 cycles in OUT -> o_OutValid and outputs constant, o_VtxReady=0 throughout; ready pulse -> IDLE on the next edge.
REQ-036 Streaming: 8 vertices, i_OutReady=1 -> 8 results in order, spaced 6 cycles apart, o_VtxCount=8.
REQ-037 Exception: stub i_PipeExc=1 on vertex 2 of 3 -> o_ExcCount=1; without the macro, 3 outputs with the second having o_Exception=1; with VSEQ_EXC_DROP_EN, 2 outputs.
REQ-038 Reset mid-SETTLE: i_Reset_n=0 on edge 2 after acceptance -> IDLE, no o_OutValid, counters 0, o_PipeVertex=0.
REQ-039 Saturation: CNT_W=3, 9 vertices with exception -> o_VtxCount and o_ExcCount both 7.
